// File: rtl/atb_trace_xbar.sv
// rtl/atb_trace_xbar.sv - ATB trace crossbar with per-source FIFOs and per-sink packet-locked round-robin
//
// atb_trace_fifo ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   push_i, wdata_i     write one entry (caller guarantees not full)
//   pop_i, rdata_o      drop head entry (caller guarantees not empty); rdata_o shows the head
//   empty_o, full_o     occupancy flags
//
// atb_trace_xbar ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   m_atid_i/m_atdata_i/m_atlast_i   per-master beat fields
//   m_atvalid_i, m_atready_o         per-master handshake
//   s_atid_o/s_atdata_o/s_atlast_o   per-sink registered beat fields
//   s_atvalid_o, s_atready_i         per-sink handshake
//   cfg_en_i, cfg_route_i            per-master forward enable and destination sink index
//   idle_o                           nothing buffered, in flight, or mid-packet

module atb_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;

    assign empty_o = (count == '0);
    assign full_o  = (count == (AW+1)'(DEPTH));
    assign rdata_o = mem[rptr];

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wptr] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_i) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_i) begin
                rptr <= rptr + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module atb_trace_xbar #(
    parameter  int NUM_MASTERS = 6,
    parameter  int NUM_SLAVES  = 2,
    parameter  int DATA_WIDTH  = 64,
    parameter  int ATID_WIDTH  = 8,
    parameter  int FIFO_DEPTH  = 8,
    localparam int SW          = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NUM_MASTERS-1:0][ATID_WIDTH-1:0]  m_atid_i,
    input  logic [NUM_MASTERS-1:0]                  m_atvalid_i,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_atdata_i,
    input  logic [NUM_MASTERS-1:0]                  m_atlast_i,
    output logic [NUM_MASTERS-1:0]                  m_atready_o,
    output logic [NUM_SLAVES-1:0][ATID_WIDTH-1:0]   s_atid_o,
    output logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]   s_atdata_o,
    output logic [NUM_SLAVES-1:0]                   s_atlast_o,
    output logic [NUM_SLAVES-1:0]                   s_atvalid_o,
    input  logic [NUM_SLAVES-1:0]                   s_atready_i,
    input  logic [NUM_MASTERS-1:0]                  cfg_en_i,
    input  logic [NUM_MASTERS-1:0][SW-1:0]          cfg_route_i,
    output logic                                    idle_o
);
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    // FIFO entry layout: {atid, atdata, atlast, dest}
    localparam int EW = ATID_WIDTH + DATA_WIDTH + 1 + SW;

    // Input side
    logic [NUM_MASTERS-1:0]          pkt_open_q;
    logic [NUM_MASTERS-1:0]          pkt_fwd_q;
    logic [NUM_MASTERS-1:0][SW-1:0]  pkt_dest_q;
    logic [NUM_MASTERS-1:0]          cfg_ok;
    logic [NUM_MASTERS-1:0]          fwd_now;
    logic [NUM_MASTERS-1:0][SW-1:0]  dest_now;
    logic [NUM_MASTERS-1:0]          ready;
    logic [NUM_MASTERS-1:0]          accept;
    logic [NUM_MASTERS-1:0]          push;
    logic [NUM_MASTERS-1:0][EW-1:0]  push_data;

    // FIFO side
    logic [NUM_MASTERS-1:0]          pop;
    logic [NUM_MASTERS-1:0][EW-1:0]  head;
    logic [NUM_MASTERS-1:0]          fifo_empty;
    logic [NUM_MASTERS-1:0]          fifo_full;
    logic [NUM_MASTERS-1:0][SW-1:0]  head_dest;
    logic [NUM_MASTERS-1:0]          head_last;

    // Sink side
    logic [NUM_SLAVES-1:0]           lock_q;
    logic [NUM_SLAVES-1:0][MW-1:0]   lock_m_q;
    logic [NUM_SLAVES-1:0][MW-1:0]   rr_q;
    logic [NUM_SLAVES-1:0]           gnt_valid;
    logic [NUM_SLAVES-1:0][MW-1:0]   gnt_idx;
    logic [NUM_SLAVES-1:0]           xfer;
    logic [MW-1:0]                   cand;

    // While a packet is open the decision captured on its first beat wins,
    // so reconfiguration never splits a packet.
    always_comb begin
        cfg_ok    = '0;
        fwd_now   = '0;
        dest_now  = '0;
        ready     = '0;
        accept    = '0;
        push      = '0;
        push_data = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            cfg_ok[m]    = cfg_en_i[m] && ({1'b0, cfg_route_i[m]} < (SW+1)'(NUM_SLAVES));
            fwd_now[m]   = pkt_open_q[m] ? pkt_fwd_q[m]  : cfg_ok[m];
            dest_now[m]  = pkt_open_q[m] ? pkt_dest_q[m] : cfg_route_i[m];
            // Discarded packets are always accepted so sources never stall.
            ready[m]     = !rst_i && (!fwd_now[m] || !fifo_full[m]);
            accept[m]    = m_atvalid_i[m] && ready[m];
            push[m]      = accept[m] && fwd_now[m];
            push_data[m] = {m_atid_i[m], m_atdata_i[m], m_atlast_i[m], dest_now[m]};
        end
    end

    assign m_atready_o = ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_open_q <= '0;
            pkt_fwd_q  <= '0;
            pkt_dest_q <= '0;
        end else begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (accept[m]) begin
                    pkt_open_q[m] <= !m_atlast_i[m];
                    if (!pkt_open_q[m]) begin
                        pkt_fwd_q[m]  <= cfg_ok[m];
                        pkt_dest_q[m] <= cfg_route_i[m];
                    end
                end
            end
        end
    end

    for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_fifo
        atb_trace_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push[m]),
            .wdata_i (push_data[m]),
            .pop_i   (pop[m]),
            .rdata_o (head[m]),
            .empty_o (fifo_empty[m]),
            .full_o  (fifo_full[m])
        );
    end

    always_comb begin
        head_dest = '0;
        head_last = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            head_dest[m] = head[m][SW-1:0];
            head_last[m] = head[m][SW];
        end
    end

    // Per-sink arbitration. A locked sink only considers its owner; an
    // unlocked sink searches from rr_q+1 upward with wrap. Scanning the
    // offsets high-to-low and overwriting leaves the nearest requester.
    always_comb begin
        gnt_valid = '0;
        gnt_idx   = '0;
        xfer      = '0;
        pop       = '0;
        cand      = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (lock_q[s]) begin
                gnt_idx[s]   = lock_m_q[s];
                gnt_valid[s] = !fifo_empty[lock_m_q[s]] && (head_dest[lock_m_q[s]] == SW'(s));
            end else begin
                for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                    cand = MW'((int'(rr_q[s]) + 1 + i) % NUM_MASTERS);
                    if (!fifo_empty[cand] && (head_dest[cand] == SW'(s))) begin
                        gnt_valid[s] = 1'b1;
                        gnt_idx[s]   = cand;
                    end
                end
            end
            xfer[s] = gnt_valid[s] && (!s_atvalid_o[s] || s_atready_i[s]);
            // Each FIFO head targets one sink only, so pops never collide.
            if (xfer[s]) begin
                pop[gnt_idx[s]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_atvalid_o <= '0;
            s_atid_o    <= '0;
            s_atdata_o  <= '0;
            s_atlast_o  <= '0;
            lock_q      <= '0;
            lock_m_q    <= '0;
            rr_q        <= {NUM_SLAVES{MW'(NUM_MASTERS - 1)}};
        end else begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
                if (xfer[s]) begin
                    s_atvalid_o[s] <= 1'b1;
                    {s_atid_o[s], s_atdata_o[s], s_atlast_o[s]} <= head[gnt_idx[s]][EW-1:SW];
                    // The round-robin pointer only advances at packet end.
                    if (head_last[gnt_idx[s]]) begin
                        lock_q[s] <= 1'b0;
                        rr_q[s]   <= gnt_idx[s];
                    end else begin
                        lock_q[s]   <= 1'b1;
                        lock_m_q[s] <= gnt_idx[s];
                    end
                end else if (s_atready_i[s]) begin
                    s_atvalid_o[s] <= 1'b0;
                end
            end
        end
    end

    assign idle_o = (&fifo_empty) && !(|s_atvalid_o) && !(|pkt_open_q) && !(|lock_q);
endmodule

// File: tb/tb_atb_trace_xbar.sv
// tb/tb_atb_trace_xbar.sv - directed vector and sequence bench for atb_trace_xbar
module tb_atb_trace_xbar;
    localparam int NM = 6;
    localparam int NS = 2;
    localparam int DW = 64;
    localparam int IW = 8;
    localparam int FD = 8;
    localparam int SW = 1;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } beat_t;

    typedef struct {
        int            m;
        logic          en;
        logic          route;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          fwd;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [NM-1:0][IW-1:0] m_atid;
    logic [NM-1:0]         m_atvalid;
    logic [NM-1:0][DW-1:0] m_atdata;
    logic [NM-1:0]         m_atlast;
    logic [NM-1:0]         m_atready;
    logic [NS-1:0][IW-1:0] s_atid;
    logic [NS-1:0][DW-1:0] s_atdata;
    logic [NS-1:0]         s_atlast;
    logic [NS-1:0]         s_atvalid;
    logic [NS-1:0]         s_atready;
    logic [NM-1:0]         cfg_en;
    logic [NM-1:0][SW-1:0] cfg_route;
    logic                  idle;

    int    checks;
    int    errors;
    int    cyc;
    int    acc_cnt [NM];
    int    acc_first [NM];
    logic [NM-1:0] rdy_s;
    logic [NM-1:0] acc;
    beat_t mq [NM][$];
    beat_t got [NS][$];
    vec_t  vecs [6];

    atb_trace_xbar #(
        .NUM_MASTERS (NM),
        .NUM_SLAVES  (NS),
        .DATA_WIDTH  (DW),
        .ATID_WIDTH  (IW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .m_atid_i    (m_atid),
        .m_atvalid_i (m_atvalid),
        .m_atdata_i  (m_atdata),
        .m_atlast_i  (m_atlast),
        .m_atready_o (m_atready),
        .s_atid_o    (s_atid),
        .s_atdata_o  (s_atdata),
        .s_atlast_o  (s_atlast),
        .s_atvalid_o (s_atvalid),
        .s_atready_i (s_atready),
        .cfg_en_i    (cfg_en),
        .cfg_route_i (cfg_route),
        .idle_o      (idle)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [DW-1:0] dv(input int m, input int p, input int b);
        return 64'hA500_0000_0000_0000 | (64'(m) << 32) | (64'(p) << 16) | 64'(b);
    endfunction

    function automatic beat_t mk(input int m, input int p, input int b, input logic last);
        beat_t r;
        r.id   = 8'(m * 16 + p);
        r.data = dv(m, p, b);
        r.last = last;
        r.cyc  = 0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string name, input int s, input int i, input beat_t e);
        checks++;
        if (got[s].size() <= i) begin
            errors++;
            $display("FAIL %s: beat %0d missing on sink %0d (only %0d seen)", name, i, s, got[s].size());
        end else if (got[s][i].id !== e.id || got[s][i].data !== e.data || got[s][i].last !== e.last) begin
            errors++;
            $display("FAIL %s: got id %h data %h last %b expected id %h data %h last %b",
                     name, got[s][i].id, got[s][i].data, got[s][i].last, e.id, e.data, e.last);
        end
    endtask

    function automatic int got_cyc(input int s, input int i);
        if (got[s].size() <= i) return -1;
        return got[s][i].cyc;
    endfunction

    // One clock: present queued beats, sample handshakes at negedge, retire after posedge.
    task automatic step();
        beat_t b;
        for (int m = 0; m < NM; m++) begin
            if (mq[m].size() > 0) begin
                m_atvalid[m] = 1'b1;
                m_atid[m]    = mq[m][0].id;
                m_atdata[m]  = mq[m][0].data;
                m_atlast[m]  = mq[m][0].last;
            end else begin
                m_atvalid[m] = 1'b0;
                m_atid[m]    = '0;
                m_atdata[m]  = '0;
                m_atlast[m]  = 1'b0;
            end
        end
        @(negedge clk);
        rdy_s = m_atready;
        acc   = m_atvalid & m_atready;
        for (int s = 0; s < NS; s++) begin
            if (s_atvalid[s] && s_atready[s]) begin
                b.id   = s_atid[s];
                b.data = s_atdata[s];
                b.last = s_atlast[s];
                b.cyc  = cyc;
                got[s].push_back(b);
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < NM; m++) begin
            if (acc[m]) begin
                if (acc_cnt[m] == 0) acc_first[m] = cyc;
                acc_cnt[m]++;
                void'(mq[m].pop_front());
            end
        end
        cyc++;
    endtask

    task automatic clr();
        for (int s = 0; s < NS; s++) got[s].delete();
        for (int m = 0; m < NM; m++) begin
            mq[m].delete();
            acc_cnt[m]   = 0;
            acc_first[m] = -1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < 400) begin
            step();
            n++;
            busy = !idle;
            for (int m = 0; m < NM; m++) if (mq[m].size() > 0) busy = 1'b1;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: still busy after %0d cycles", name, n);
        end
        step();
        step();
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        clr();
    endtask

    initial begin
        int bad;
        int idx;
        beat_t e;
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        m_atvalid = '0;
        m_atid    = '0;
        m_atdata  = '0;
        m_atlast  = '0;
        s_atready = '1;
        cfg_en    = '1;
        cfg_route = '0;
        clr();

        // {master, en, route, atid, data, expect forwarded}
        vecs[0] = '{0, 1'b1, 1'b0, 8'h10, 64'h0000_0000_0000_1001, 1'b1};
        vecs[1] = '{1, 1'b1, 1'b1, 8'h21, 64'hDEAD_BEEF_0000_0001, 1'b1};
        vecs[2] = '{5, 1'b1, 1'b0, 8'h5F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[3] = '{2, 1'b0, 1'b1, 8'h32, 64'h1234_5678_9ABC_DEF0, 1'b0};
        vecs[4] = '{4, 1'b1, 1'b1, 8'h44, 64'h0000_0000_0000_0000, 1'b1};
        vecs[5] = '{3, 1'b0, 1'b0, 8'h33, 64'h5555_AAAA_5555_AAAA, 1'b0};

        @(posedge clk);
        #1;

        // Reset: ready held low even though every master would otherwise accept.
        step();
        step();
        chk("rst_ready_low", 72'(rdy_s), 72'(0));
        rst = 1'b0;
        chk("rst_idle", 72'(idle), 72'(1));
        chk("rst_valid", 72'(s_atvalid), 72'(0));
        chk("rst_fields", 72'(|{s_atid, s_atdata, s_atlast}), 72'(0));

        // Single-beat vectors.
        for (int v = 0; v < 6; v++) begin
            clr();
            cfg_en    = '0;
            cfg_route = '0;
            cfg_en[vecs[v].m]    = vecs[v].en;
            cfg_route[vecs[v].m] = vecs[v].route;
            e.id   = vecs[v].id;
            e.data = vecs[v].data;
            e.last = 1'b1;
            e.cyc  = 0;
            mq[vecs[v].m].push_back(e);
            drain($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_accepted", v), 72'(acc_cnt[vecs[v].m]), 72'(1));
            chk($sformatf("vec%0d_sink0_cnt", v), 72'(got[0].size()),
                72'(vecs[v].fwd && vecs[v].route == 1'b0));
            chk($sformatf("vec%0d_sink1_cnt", v), 72'(got[1].size()),
                72'(vecs[v].fwd && vecs[v].route == 1'b1));
            if (vecs[v].fwd) chk_beat($sformatf("vec%0d_beat", v), int'(vecs[v].route), 0, e);
            chk($sformatf("vec%0d_idle", v), 72'(idle), 72'(1));
        end

        // Two sinks fed by different masters in the same cycle.
        clr();
        cfg_en = 6'b010001;
        cfg_route = '0;
        cfg_route[4] = 1'b1;
        mq[0].push_back(mk(0, 9, 0, 1'b1));
        mq[4].push_back(mk(4, 9, 0, 1'b1));
        drain("par");
        chk_beat("par_s0", 0, 0, mk(0, 9, 0, 1'b1));
        chk_beat("par_s1", 1, 0, mk(4, 9, 0, 1'b1));
        chk("par_same_cycle", 72'(got_cyc(0, 0)), 72'(got_cyc(1, 0)));

        // 3-beat packet, latency and idle return.
        clr();
        cfg_en = 6'b000001;
        cfg_route = '0;
        for (int b = 0; b < 3; b++) mq[0].push_back(mk(0, 1, b, b == 2));
        drain("lat");
        for (int b = 0; b < 3; b++) chk_beat($sformatf("lat_beat%0d", b), 0, b, mk(0, 1, b, b == 2));
        chk("lat_first", 72'(got_cyc(0, 0) - acc_first[0]), 72'(2));
        chk("lat_third", 72'(got_cyc(0, 2) - acc_first[0]), 72'(4));
        chk("lat_idle", 72'(idle), 72'(1));

        // Round-robin between masters 1 and 2 on sink 1, whole packets only.
        do_reset();
        cfg_en = 6'b000110;
        cfg_route = '0;
        cfg_route[1] = 1'b1;
        cfg_route[2] = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int mm = 1; mm <= 2; mm++) begin
                mq[mm].push_back(mk(mm, p, 0, 1'b0));
                mq[mm].push_back(mk(mm, p, 1, 1'b1));
            end
        end
        drain("rr");
        idx = 0;
        for (int p = 0; p < 4; p++) begin
            for (int mm = 1; mm <= 2; mm++) begin
                for (int b = 0; b < 2; b++) begin
                    chk_beat($sformatf("rr_beat%0d", idx), 1, idx, mk(mm, p, b, b == 1));
                    idx++;
                end
            end
        end
        chk("rr_sink1_cnt", 72'(got[1].size()), 72'(16));
        chk("rr_sink0_cnt", 72'(got[0].size()), 72'(0));

        // Master 3 disabled mid-stream, re-enabled mid-packet: that packet stays dropped.
        clr();
        cfg_en = 6'b001000;
        cfg_route = '0;
        mq[3].push_back(mk(3, 0, 0, 1'b0));
        mq[3].push_back(mk(3, 0, 1, 1'b1));
        for (int k = 0; k < 10 && mq[3].size() > 0; k++) step();
        cfg_en[3] = 1'b0;
        mq[3].push_back(mk(3, 1, 0, 1'b0));
        mq[3].push_back(mk(3, 1, 1, 1'b1));
        step();
        chk("dis_ready_b0", 72'(rdy_s[3]), 72'(1));
        cfg_en[3] = 1'b1;
        step();
        chk("dis_ready_b1", 72'(rdy_s[3]), 72'(1));
        chk("dis_accepted", 72'(acc_cnt[3]), 72'(4));
        mq[3].push_back(mk(3, 2, 0, 1'b1));
        drain("dis");
        chk("dis_cnt", 72'(got[0].size()), 72'(3));
        chk_beat("dis_a0", 0, 0, mk(3, 0, 0, 1'b0));
        chk_beat("dis_a1", 0, 1, mk(3, 0, 1, 1'b1));
        chk_beat("dis_c0", 0, 2, mk(3, 2, 0, 1'b1));

        // Route change after the first beat must not split the packet.
        clr();
        cfg_en = 6'b000001;
        cfg_route = '0;
        for (int b = 0; b < 4; b++) mq[0].push_back(mk(0, 3, b, b == 3));
        step();
        cfg_route[0] = 1'b1;
        drain("rt_a");
        mq[0].push_back(mk(0, 4, 0, 1'b1));
        drain("rt_b");
        chk("rt_sink0_cnt", 72'(got[0].size()), 72'(4));
        for (int b = 0; b < 4; b++) chk_beat($sformatf("rt_beat%0d", b), 0, b, mk(0, 3, b, b == 3));
        chk("rt_sink1_cnt", 72'(got[1].size()), 72'(1));
        chk_beat("rt_next", 1, 0, mk(0, 4, 0, 1'b1));

        // Backpressure: sink 0 stalled for 20 cycles.
        clr();
        cfg_en = 6'b000001;
        cfg_route = '0;
        s_atready[0] = 1'b0;
        for (int p = 0; p < 10; p++)
            for (int b = 0; b < 3; b++) mq[0].push_back(mk(0, 10 + p, b, b == 2));
        for (int k = 0; k < 20; k++) begin
            step();
            if (k == 4) chk("bp_hold_early", 72'(s_atdata[0]), 72'(dv(0, 10, 0)));
        end
        chk("bp_accepted", 72'(acc_cnt[0]), 72'(FD + 1));
        chk("bp_ready_low", 72'(rdy_s[0]), 72'(0));
        chk("bp_valid", 72'(s_atvalid[0]), 72'(1));
        chk("bp_hold_data", 72'(s_atdata[0]), 72'(dv(0, 10, 0)));
        chk("bp_hold_id", 72'(s_atid[0]), 72'(8'(10)));
        s_atready[0] = 1'b1;
        drain("bp");
        chk("bp_cnt", 72'(got[0].size()), 72'(30));
        bad = 0;
        for (int i = 0; i < 30 && i < got[0].size(); i++) begin
            e = mk(0, 10 + i / 3, i % 3, (i % 3) == 2);
            if (got[0][i].data !== e.data || got[0][i].last !== e.last) bad++;
        end
        chk("bp_order_errors", 72'(bad), 72'(0));

        // Reset with both FIFOs full and packets open.
        clr();
        cfg_en = 6'b000011;
        cfg_route = '0;
        cfg_route[1] = 1'b1;
        s_atready = '0;
        for (int b = 0; b < 20; b++) begin
            mq[0].push_back(mk(0, 20, b, 1'b0));
            mq[1].push_back(mk(1, 20, b, 1'b0));
        end
        for (int k = 0; k < 12; k++) step();
        chk("mr_full0", 72'(acc_cnt[0]), 72'(FD + 1));
        chk("mr_full1", 72'(acc_cnt[1]), 72'(FD + 1));
        rst = 1'b1;
        step();
        chk("mr_ready_low", 72'(rdy_s), 72'(0));
        chk("mr_valid", 72'(s_atvalid), 72'(0));
        chk("mr_idle", 72'(idle), 72'(1));
        rst = 1'b0;
        clr();
        s_atready = '1;
        mq[0].push_back(mk(0, 21, 0, 1'b0));
        mq[0].push_back(mk(0, 21, 1, 1'b1));
        drain("mr");
        chk("mr_cnt0", 72'(got[0].size()), 72'(2));
        chk_beat("mr_b0", 0, 0, mk(0, 21, 0, 1'b0));
        chk_beat("mr_b1", 0, 1, mk(0, 21, 1, 1'b1));
        chk("mr_cnt1", 72'(got[1].size()), 72'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
